// File: rtl/max_unpool_6x6_if.sv
// Handshake and data bundle for the 6x6 max-unpool block.
// Handshake: start is a request accepted only on an enabled clock edge while
// the block is idle; busy stays high from acceptance until done falls, and
// done is a single enabled-cycle pulse marking out_array complete and stable.
// enable low freezes everything, including a pending done.
interface max_unpool_6x6_if #(
  parameter int DATA_W = 8
);
  logic                  enable;
  logic                  start;
  logic [9*DATA_W-1:0]   pool_vals;
  logic [17:0]           pool_idx;
  logic [36*DATA_W-1:0]  out_array;
  logic                  busy;
  logic                  done;
  logic [1:0]            dbg_state;

  modport master (
    output enable, start, pool_vals, pool_idx,
    input  out_array, busy, done, dbg_state
  );

  modport slave (
    input  enable, start, pool_vals, pool_idx,
    output out_array, busy, done, dbg_state
  );
endinterface

// File: rtl/max_unpool_6x6.sv
// 3x3 -> 6x6 max unpooling: each pooled value is scattered to the argmax
// position of its 2x2 window, one window per enabled cycle; all other
// elements stay zero.
module max_unpool_6x6 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  max_unpool_6x6_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SCATTER = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [9*DATA_W-1:0]   r_vals;
  logic [17:0]           r_idx;
  logic [36*DATA_W-1:0]  r_out;
  logic                  r_busy;
  logic                  r_done;

  int                    w_k;
  int                    w_row;
  int                    w_col;
  int                    w_elem;
  logic [1:0]            w_sel;
  logic [DATA_W-1:0]     w_val;

  // State register; enable low holds the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (bus.enable) begin
      r_state <= w_next;
    end
  end

  // Next-state logic: accept start in idle, leave scatter after window 8.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_next = S_SCATTER;
      S_SCATTER: if (r_cnt == 4'd8) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Target element of the current window: row 2*(k/3)+idx[1], col 2*(k%3)+idx[0].
  always_comb begin
    w_k    = int'(r_cnt);
    w_val  = r_vals[w_k*DATA_W +: DATA_W];
    w_sel  = r_idx[2*w_k +: 2];
    w_row  = 2 * (w_k / 3) + int'(w_sel[1]);
    w_col  = 2 * (w_k % 3) + int'(w_sel[0]);
    w_elem = 6 * w_row + w_col;
  end

  // Datapath: capture on start, scatter one window per cycle, flag completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 4'd0;
      r_vals <= '0;
      r_idx  <= '0;
      r_out  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (bus.enable) begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_vals <= bus.pool_vals;
            r_idx  <= bus.pool_idx;
            r_out  <= '0;
            r_cnt  <= 4'd0;
            r_busy <= 1'b1;
            r_done <= 1'b0;
          end
        end
        S_SCATTER: begin
          r_out[w_elem*DATA_W +: DATA_W] <= w_val;
          // Counter parks at 8 so the last window index stays valid.
          if (r_cnt == 4'd8) begin
            r_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
        default: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_array = r_out;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_max_unpool_6x6.sv
// Directed bench for max_unpool_6x6: hand-derived 6x6 maps, latency,
// busy length, enable stall, ignored restart, mid-run reset, back-to-back.
module tb_max_unpool_6x6;
  localparam int DATA_W = 8;
  localparam int MW     = 36 * DATA_W;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [MW-1:0] exp_q[$];

  max_unpool_6x6_if #(.DATA_W(DATA_W)) u_if ();

  max_unpool_6x6 #(.DATA_W(DATA_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] put(input logic [MW-1:0] m, input int i, input int j,
                                        input logic [DATA_W-1:0] v);
    logic [MW-1:0] t;
    t = m;
    t[(6*i+j)*DATA_W +: DATA_W] = v;
    return t;
  endfunction

  // Expected map from the argmax placement rule of a 2x2 window.
  function automatic logic [MW-1:0] exp_map(input logic [9*DATA_W-1:0] v, input logic [17:0] ix);
    logic [MW-1:0] m;
    int k;
    m = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        k = 3*r + c;
        m = put(m, 2*r + int'(ix[2*k+1]), 2*c + int'(ix[2*k]), v[k*DATA_W +: DATA_W]);
      end
    end
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start one operation and wait (bounded) for done; edges counts E0 as 1.
  task automatic run_op(input bit stall, input bit disturb, output int edges, output int busy_n);
    edges  = 0;
    busy_n = 0;
    u_if.start = 1'b1;
    step();
    edges = 1;
    u_if.start = 1'b0;
    if (u_if.busy) busy_n++;
    while (!u_if.done && edges < 40) begin
      if (stall && edges == 5) begin
        u_if.enable = 1'b0;
        repeat (3) begin
          step();
          edges++;
        end
        u_if.enable = 1'b1;
      end
      if (disturb && edges == 6) begin
        u_if.pool_vals = ~u_if.pool_vals;
        u_if.pool_idx  = ~u_if.pool_idx;
        u_if.start     = 1'b1;
      end
      step();
      edges++;
      u_if.start = 1'b0;
      if (u_if.busy) busy_n++;
    end
  endtask

  // Pop the expected map and compare, then check the done pulse ends cleanly.
  task automatic check_result(input string tag);
    logic [MW-1:0] e;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk({tag, "_map"}, u_if.out_array, e);
    step();
    chk({tag, "_done_fall"}, MW'(u_if.done), MW'(0));
    chk({tag, "_busy_fall"}, MW'(u_if.busy), MW'(0));
    chk({tag, "_idle"}, MW'(u_if.dbg_state), MW'(0));
    step();
    chk({tag, "_retain"}, u_if.out_array, e);
  endtask

  initial begin
    int edges;
    int busy_n;
    int d1;
    logic [MW-1:0] m;
    logic [9*DATA_W-1:0] v;
    logic [17:0] ix;

    n_checks = 0;
    n_fail   = 0;
    rst_n          = 1'b0;
    u_if.enable    = 1'b1;
    u_if.start     = 1'b0;
    u_if.pool_vals = '0;
    u_if.pool_idx  = '0;
    #1;
    chk("rst_out", u_if.out_array, '0);
    chk("rst_busy", MW'(u_if.busy), MW'(0));
    chk("rst_done", MW'(u_if.done), MW'(0));
    chk("rst_state", MW'(u_if.dbg_state), MW'(0));
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();

    // Test 1: values 1..9, idx 00 -> out(2r,2c)=3r+c+1.
    for (int k = 0; k < 9; k++) v[k*DATA_W +: DATA_W] = DATA_W'(k + 1);
    u_if.pool_vals = v;
    u_if.pool_idx  = 18'h0;
    m = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        m = put(m, 2*r, 2*c, DATA_W'(3*r + c + 1));
    exp_q.push_back(m);
    run_op(1'b0, 1'b0, edges, busy_n);
    chk("t1_latency", MW'(edges), MW'(10));
    check_result("t1");

    // Test 2: all FF, idx 11 -> out(2r+1,2c+1)=FF; busy for 10 cycles.
    u_if.pool_vals = '1;
    u_if.pool_idx  = 18'h3FFFF;
    m = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        m = put(m, 2*r+1, 2*c+1, 8'hFF);
    exp_q.push_back(m);
    run_op(1'b0, 1'b0, edges, busy_n);
    chk("t2_latency", MW'(edges), MW'(10));
    chk("t2_busy_len", MW'(busy_n), MW'(10));
    check_result("t2");

    // Test 3: enable dropped 3 cycles after the 4th scatter edge.
    for (int k = 0; k < 9; k++) begin
      v[k*DATA_W +: DATA_W] = DATA_W'(8'hA0 + k);
      ix[2*k +: 2] = 2'(k % 4);
    end
    u_if.pool_vals = v;
    u_if.pool_idx  = ix;
    exp_q.push_back(exp_map(v, ix));
    run_op(1'b1, 1'b0, edges, busy_n);
    chk("t3_latency", MW'(edges), MW'(13));
    check_result("t3");

    // Test 4: inputs change and start pulses mid-scatter; E0 capture wins.
    for (int k = 0; k < 9; k++) v[k*DATA_W +: DATA_W] = DATA_W'(8'h30 + 7*k);
    ix = 18'h0E4E4;
    u_if.pool_vals = v;
    u_if.pool_idx  = ix;
    exp_q.push_back(exp_map(v, ix));
    run_op(1'b0, 1'b1, edges, busy_n);
    chk("t4_latency", MW'(edges), MW'(10));
    check_result("t4");

    // Test 5: reset during scatter clears outputs immediately.
    u_if.pool_vals = '1;
    u_if.pool_idx  = 18'h0;
    u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out", u_if.out_array, '0);
    chk("t5_rst_busy", MW'(u_if.busy), MW'(0));
    chk("t5_rst_done", MW'(u_if.done), MW'(0));
    #2;
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 9; k++) v[k*DATA_W +: DATA_W] = DATA_W'(8'h11 * (k + 1));
    ix = 18'h1B1B1;
    u_if.pool_vals = v;
    u_if.pool_idx  = ix;
    exp_q.push_back(exp_map(v, ix));
    run_op(1'b0, 1'b0, edges, busy_n);
    chk("t5_latency", MW'(edges), MW'(10));
    check_result("t5");

    // Test 6: start held high across two operations (idx 01 then 10).
    for (int k = 0; k < 9; k++) v[k*DATA_W +: DATA_W] = DATA_W'(8'h50 + k);
    u_if.pool_vals = v;
    u_if.pool_idx  = 18'h15555;
    m = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        m = put(m, 2*r, 2*c+1, DATA_W'(8'h50 + 3*r + c));
    u_if.start = 1'b1;
    step();
    edges = 1;
    while (!u_if.done && edges < 40) begin
      step();
      edges++;
    end
    d1 = edges;
    chk("t6_first_latency", MW'(d1), MW'(10));
    chk("t6_first_map", u_if.out_array, m);
    for (int k = 0; k < 9; k++) v[k*DATA_W +: DATA_W] = DATA_W'(8'hC0 + k);
    u_if.pool_vals = v;
    u_if.pool_idx  = 18'h2AAAA;
    m = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        m = put(m, 2*r+1, 2*c, DATA_W'(8'hC0 + 3*r + c));
    step();
    edges++;
    while (!u_if.done && edges < 80) begin
      step();
      edges++;
    end
    u_if.start = 1'b0;
    chk("t6_gap", MW'(edges - d1), MW'(11));
    exp_q.push_back(m);
    check_result("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
